// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch-stage PC register and single-outstanding instruction-memory requester.
// Delivers one fetched word to IF/ID with a valid flag; flushes redirect the PC and drop stale responses.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    input  logic        stallF,
    input  logic        flushF,
    input  logic [31:0] flush_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pcF,
    output logic [31:0] pc_plus4F,
    output logic [31:0] instF,
    output logic        validF
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

    state_t state, state_nx;
    logic   discard, discard_nx;
    logic   valid;
    logic   accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_REQ;
            discard <= 1'b0;
        end else begin
            state   <= state_nx;
            discard <= discard_nx;
        end
    end

    // discard marks a request already accepted by memory whose response must be dropped
    always_comb begin
        state_nx   = state;
        discard_nx = discard;
        if (state == S_REQ) begin
            state_nx   = inst_addr_ok ? S_WAIT : S_REQ;
            discard_nx = flushF && inst_addr_ok;
        end else if (state == S_WAIT) begin
            state_nx   = !inst_data_ok ? S_WAIT : (discard || flushF) ? S_REQ : S_OUT;
            discard_nx = inst_data_ok ? 1'b0 : (discard || flushF);
        end else if (state == S_OUT) begin
            state_nx   = (flushF || !stallF) ? S_REQ : S_OUT;
        end else begin
            state_nx   = S_REQ;
            discard_nx = 1'b0;
        end
    end

    assign accept = (state == S_WAIT) && inst_data_ok && !discard && !flushF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcF   <= RESET_PC;
            instF <= 32'h0;
            valid <= 1'b0;
        end else begin
            if (flushF)
                pcF <= flush_pc;
            else if (state == S_OUT && !stallF)
                pcF <= npc;
            if (accept)
                instF <= inst_rdata;
            valid <= flushF ? 1'b0 : accept ? 1'b1 : (state == S_OUT) ? stallF : valid;
        end
    end

    always_comb begin
        inst_req  = rst_n && (state == S_REQ);
        inst_addr = pcF;
        pc_plus4F = pcF + 32'd4;
        validF    = valid;
    end
endmodule
